// File: rtl/dmem_access_ctrl_if.sv
// Word-SRAM request/ack bus between the MEM-stage access controller and the data SRAM.
interface dmem_access_ctrl_if #(
   parameter int ADDR_WIDTH = 9
);
   logic                  sram_req;
   logic                  sram_we;
   logic [ADDR_WIDTH-3:0] sram_addr;
   logic [3:0]            sram_be;
   logic [31:0]           sram_wdata;
   logic                  sram_ack;
   logic [31:0]           sram_rdata;

   modport master (
      output sram_req, sram_we, sram_addr, sram_be, sram_wdata,
      input  sram_ack, sram_rdata
   );

   modport slave (
      input  sram_req, sram_we, sram_addr, sram_be, sram_wdata,
      output sram_ack, sram_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store controller: one word-SRAM transaction per access, pipeline stall
// while outstanding, load extension, misalignment rejection and SRAM timeout detection.
module dmem_access_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_stall,
   output logic                  o_misalign,
   output logic                  o_bus_err,
   dmem_access_ctrl_if.master    sram
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t                r_state, w_next;
   logic                  r_we, r_bus_err;
   logic [3:0]            r_be;
   logic [ADDR_WIDTH-3:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata, r_rd_data;
   logic [2:0]            r_f3;
   logic [1:0]            r_off;
   logic [CW-1:0]         r_cnt;

   logic                  w_valid, w_is_b, w_is_h, w_misal, w_start;
   logic [3:0]            w_be;
   logic [DATA_WIDTH-1:0] w_wdata, w_shift, w_ld;

   // funct3[1:0] selects size (00 B, 01 H, else W); funct3[2] selects zero-extension
   assign w_valid = i_mem_read | i_mem_write;
   assign w_is_b  = (i_funct3[1:0] == 2'b00);
   assign w_is_h  = (i_funct3[1:0] == 2'b01);
   assign w_misal = w_is_h ? i_addr[0] : (!w_is_b && (i_addr[1:0] != 2'b00));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_wr_data;
      case (i_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wr_data[7:0]}};
         end
         2'b01: begin
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_wr_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Right-align the addressed lane, then extend by the latched size/sign
   assign w_shift = sram.sram_rdata >> {r_off, 3'b000};

   always_comb begin
      w_ld = sram.sram_rdata;
      case (r_f3[1:0])
         2'b00:   w_ld = {{24{~r_f3[2] & w_shift[7]}}, w_shift[7:0]};
         2'b01:   w_ld = {{16{~r_f3[2] & w_shift[15]}}, w_shift[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      w_next     = r_state;
      o_stall    = 1'b0;
      o_misalign = 1'b0;
      w_start    = 1'b0;
      if (!i_rst) begin
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  if (w_misal) begin
                     o_misalign = 1'b1;
                  end else begin
                     o_stall = 1'b1;
                     w_start = 1'b1;
                     w_next  = S_REQ;
                  end
               end
            end
            S_REQ: begin
               o_stall = 1'b1;
               if (sram.sram_ack || (r_cnt == LAST)) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_we      <= 1'b0;
         r_be      <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_f3      <= '0;
         r_off     <= '0;
         r_cnt     <= '0;
         r_rd_data <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_bus_err <= 1'b0;
         if (w_start) begin
            r_we    <= i_mem_write;
            r_be    <= i_mem_write ? w_be : 4'b0000;
            r_addr  <= i_addr[ADDR_WIDTH-1:2];
            r_wdata <= w_wdata;
            r_f3    <= i_funct3;
            r_off   <= i_addr[1:0];
            r_cnt   <= '0;
         end
         if (r_state == S_REQ) begin
            r_cnt <= r_cnt + 1'b1;
            if (sram.sram_ack) begin
               if (!r_we) r_rd_data <= w_ld;
            end else if (r_cnt == LAST) begin
               r_bus_err <= 1'b1;
               if (!r_we) r_rd_data <= '0;
            end
         end
      end
   end

   assign o_rd_data       = o_misalign ? '0 : r_rd_data;
   assign o_bus_err       = r_bus_err;
   assign sram.sram_req   = (r_state == S_REQ);
   assign sram.sram_we    = r_we;
   assign sram.sram_addr  = r_addr;
   assign sram.sram_be    = r_be;
   assign sram.sram_wdata = r_wdata;
endmodule
